// File: rtl/fp32_add_arbiter_if.sv
// fp32_add_arbiter_if: requester handshake and response bundle for fp32_add_arbiter
interface fp32_add_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid;
    logic [NUM_REQ*32-1:0] req_a, req_b;
    logic [31:0]           rsp_result;
    modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_result);
    modport slave (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_result);
endinterface

// File: rtl/fp32_add_arbiter.sv
// fp32_add_arbiter: round-robin scheduler sharing one fp32_add pipeline among NUM_REQ requesters
// Optional issued-op counter built only when FP32_ADD_ARB_STATS_EN is defined.
module fp32_add_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 2,
    parameter int TAG_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fp32_add_arbiter_if.slave bus,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    input  logic [31:0]       add_result,
    output logic              busy,
    output logic [31:0]       stat_issued
);
    localparam int DEPTH = ADD_LATENCY + 1;
    localparam logic [NUM_REQ-1:0] lsb = NUM_REQ'(1);

    logic [TAG_W-1:0] rr_ptr, grant, idx;
    logic             found, accept;
    logic [DEPTH-1:0] pipe_vld;
    logic [TAG_W-1:0] pipe_tag [DEPTH];

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // outputs are forced quiet while reset is asserted
    assign accept         = rst_n & found;
    assign bus.req_ready  = accept ? lsb << grant : '0;
    assign bus.rsp_valid  = (rst_n & pipe_vld[DEPTH-1]) ? lsb << pipe_tag[DEPTH-1] : '0;
    assign bus.rsp_result = add_result;
    assign busy           = rst_n & (|pipe_vld | |bus.req_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            pipe_vld <= '0;
            add_a    <= '0;
            add_b    <= '0;
            for (int k = 0; k < DEPTH; k++) pipe_tag[k] <= '0;
        end else begin
            if (accept) rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            add_a       <= accept ? bus.req_a[int'(grant)*32 +: 32] : '0;
            add_b       <= accept ? bus.req_b[int'(grant)*32 +: 32] : '0;
            pipe_vld    <= {pipe_vld[DEPTH-2:0], accept};
            pipe_tag[0] <= grant;
            for (int k = 1; k < DEPTH; k++) pipe_tag[k] <= pipe_tag[k-1];
        end
    end

`ifdef FP32_ADD_ARB_STATS_EN
    always_ff @(posedge clk) stat_issued <= !rst_n ? '0 : stat_issued + 32'(accept);
`else
    assign stat_issued = '0;
`endif
endmodule
